down_timer8: RTL and testbench
==============================

DOWN_TIMER8 -- requirements
Module: down_timer8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of count, load_value and reload register.
REQ-002 SHALL have parameter PRE_W, default 8, bit width of prescale and the internal prescaler counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_value  input  WIDTH  start/reload count value, sampled on accepted start.
REQ-006 SHALL have port prescale  input  PRE_W  tick divider; one tick every prescale+1 cycles, sampled on accepted start.
REQ-007 SHALL have port auto_reload  input  1  periodic mode select, sampled on accepted start.
REQ-008 SHALL have port start  input  1  load and run request, level-sampled each cycle.
REQ-009 SHALL have port stop  input  1  halt request, level-sampled each cycle.
REQ-010 SHALL have port count  output  WIDTH  current count value, registered.
REQ-011 SHALL have port tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-012 SHALL have port busy  output  1  high while in RUN, registered.

Function
REQ-013 SHALL implement states IDLE and RUN; busy = 1 exactly when state is RUN.
REQ-014 SHALL, on start=1 and stop=0 in any state: count <= load_value, reload <= load_value, prescaler <= 0, latch prescale and auto_reload, state <= RUN (restart if already running); visible after that same edge.
REQ-015 SHALL, when start and stop are both 1, give stop priority: state <= IDLE, count holds.
REQ-016 SHALL, on stop=1 in RUN, go to IDLE on that edge with count frozen at its current value and tc=0.
REQ-017 SHALL, in RUN, increment prescaler each cycle; when prescaler equals the latched prescale, generate a tick and clear prescaler to 0.
REQ-018 SHALL, on a tick with count > 1, decrement count by 1, no other change.
REQ-019 SHALL, on a tick with count == 1 and auto_reload latched 0: count <= 0, tc <= 1, state <= IDLE.
REQ-020 SHALL, on a tick with count == 1 and auto_reload latched 1: count <= reload (never shows 0), tc <= 1, state stays RUN, prescaler restarts at 0.
REQ-021 SHALL, on accepted start with load_value == 0: count <= 0, state <= IDLE, tc <= 1 on the following edge only, regardless of auto_reload (no continuous tc).
REQ-022 SHALL hold tc at 0 in every cycle not specified in REQ-019..021; tc never high two consecutive cycles unless prescale == 0 and reload == 1 in periodic mode.
REQ-023 SHALL give one-shot duration load_value*(prescale+1) cycles from start edge to tc edge; periodic tc period reload*(prescale+1) cycles.
REQ-024 SHALL never wrap count below 0; count == 0 in RUN is unreachable.
REQ-025 SHALL ignore changes on load_value, prescale, auto_reload except at accepted start.

Reset
REQ-026 SHALL, while reset=1, asynchronously force count=0, tc=0, busy=0, state=IDLE, prescaler=0, reload=0, latched prescale=0, latched auto_reload=0.
REQ-027 SHALL, when reset asserts mid-RUN, abort without a tc pulse; first edge after release behaves as IDLE.

Structure
REQ-028 SHALL place the state encoding typedef (IDLE, RUN) and default WIDTH/PRE_W constants in shared package timer_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_gen (clk, reset, clear, enable, prescale -> tick pulse).
REQ-030 SHALL keep all outputs driven directly from registers; no combinational path input-to-output.

Verification
REQ-031 SHALL check one-shot: load_value=5, prescale=2, auto_reload=0, start 1 cycle -> count 5,4,3,2,1,0 every 3 cycles, tc one pulse 15 cycles after start edge, busy falls with it.
REQ-032 SHALL check periodic: load_value=3, prescale=0, auto_reload=1 -> count 3,2,1,3,2,1..., tc every 3 cycles, busy stays 1.
REQ-033 SHALL check stop/start collision: during RUN at count=4 assert start and stop together -> IDLE, count holds 4, no tc.
REQ-034 SHALL check zero load: load_value=0, auto_reload=1, start -> count 0, busy 0, exactly one tc pulse next cycle, none thereafter.
REQ-035 SHALL check restart: running at count=2, start with load_value=9 -> count 9 after edge, prescaler cleared, no tc.
REQ-036 SHALL check reset mid-run: assert reset asynchronously at count=1 before tick -> count=0, busy=0, tc never pulses.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encoding and default widths for the down-counting timer.
package timer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: while enabled, emits one tick every prescale+1 cycles.
module tick_gen #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // The tick is consumed in the same cycle by the count register, so it
  // decodes the current prescaler value rather than adding a cycle of delay.
  assign tick = enable && (cnt == prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/down_timer8.sv
// Loadable down-counter with prescaled tick, one-shot or periodic reload,
// and a one-cycle terminal-count pulse.
module down_timer8
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic [PRE_W-1:0] prescale,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output timer_state_e     state_dbg
);

  // Handshake: start and stop are level requests sampled every rising edge;
  // stop wins when both are high, and there is no ready/acknowledge.

  timer_state_e     state, state_nx;
  logic [WIDTH-1:0] count_nx, reload, reload_nx;
  logic [PRE_W-1:0] pre_q, pre_nx;
  logic             auto_q, auto_nx;
  logic             tc_nx;
  logic             zero_pend, pend_nx;
  logic             tick;
  logic             accept;

  assign accept    = start && !stop;
  assign state_dbg = state;

  tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept || (state != RUN)),
    .enable   (state == RUN),
    .prescale (pre_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      tc        <= 1'b0;
      busy      <= 1'b0;
      reload    <= '0;
      pre_q     <= '0;
      auto_q    <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      tc        <= tc_nx;
      busy      <= (state_nx == RUN);
      reload    <= reload_nx;
      pre_q     <= pre_nx;
      auto_q    <= auto_nx;
      zero_pend <= pend_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    tc_nx     = zero_pend;
    reload_nx = reload;
    pre_nx    = pre_q;
    auto_nx   = auto_q;
    pend_nx   = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      tc_nx    = 1'b0;
    end else if (start) begin
      count_nx  = load_value;
      reload_nx = load_value;
      pre_nx    = prescale;
      auto_nx   = auto_reload;
      // A zero load expires immediately: one delayed tc, never a running state.
      if (load_value == '0) begin
        state_nx = IDLE;
        pend_nx  = 1'b1;
      end else begin
        state_nx = RUN;
      end
    end else if ((state == RUN) && tick) begin
      if (count > WIDTH'(1)) begin
        count_nx = count - WIDTH'(1);
      end else begin
        tc_nx = 1'b1;
        if (auto_q) begin
          count_nx = reload;
        end else begin
          count_nx = '0;
          state_nx = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer8.sv
// Directed and randomized checks of down_timer8 against an arithmetic
// model of count/tc/busy as a function of cycles elapsed since start.
module tb_down_timer8;
  import timer_pkg::*;

  localparam int WIDTH = 8;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] load_value;
  logic [PRE_W-1:0] prescale;
  logic             auto_reload;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  timer_state_e     state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH+1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  down_timer8 #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_value  (load_value),
    .prescale    (prescale),
    .auto_reload (auto_reload),
    .start       (start),
    .stop        (stop),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {count, tc, busy} k cycles after an accepted start.
  function automatic logic [WIDTH+1:0] model(input int l, input int p, input int a, input int k);
    int per, c, t, b;
    per = p + 1;
    if (l == 0) begin
      c = 0; b = 0; t = (k == 1) ? 1 : 0;
    end else if (a != 0) begin
      c = l - ((k / per) % l);
      t = (k > 0 && (k % (l * per)) == 0) ? 1 : 0;
      b = 1;
    end else if (k < l * per) begin
      c = l - k / per; t = 0; b = 1;
    end else begin
      c = 0; b = 0; t = (k == l * per) ? 1 : 0;
    end
    return {c[WIDTH-1:0], t[0], b[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [WIDTH+1:0] e);
    logic [WIDTH+1:0] x;
    exp_q.push_back(e);
    x = exp_q.pop_front();
    chk({tag, ".count"}, 32'(count), 32'(x[WIDTH+1:2]));
    chk({tag, ".tc"},    32'(tc),    32'(x[1]));
    chk({tag, ".busy"},  32'(busy),  32'(x[0]));
    chk({tag, ".state"}, 32'(state_dbg), 32'(x[0]));
  endtask

  // Accept a start, then check n cycles (k = 0..n-1) while scrambling the
  // configuration inputs, which must be ignored outside the start edge.
  task automatic run(input string tag, input int l, input int p, input int a, input int n);
    load_value  = WIDTH'(l);
    prescale    = PRE_W'(p);
    auto_reload = a[0];
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      load_value  = WIDTH'($urandom);
      prescale    = PRE_W'($urandom);
      auto_reload = 1'($urandom);
      check_now(tag, model(l, p, a, k));
      if (k < n - 1) step();
    end
  endtask

  task automatic do_stop(input string tag, input int frozen);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_now(tag, {WIDTH'(frozen), 1'b0, 1'b0});
  endtask

  initial begin
    int l, p, a, n;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    load_value = '0; prescale = '0; auto_reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", '0);
    reset = 1'b0;
    step();
    check_now("idle", '0);

    run("oneshot", 5, 2, 0, 20);

    run("periodic", 3, 0, 1, 12);
    do_stop("periodic_stop", 1);

    run("collide_pre", 6, 1, 0, 5);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_now("collide", {WIDTH'(4), 1'b0, 1'b0});
    step(); step();
    check_now("collide_hold", {WIDTH'(4), 1'b0, 1'b0});

    run("zero", 0, 3, 1, 6);

    run("restart_pre", 4, 3, 0, 10);
    run("restart", 9, 3, 0, 12);

    run("rst_pre", 2, 1, 0, 4);
    #2 reset = 1'b1;
    #1 check_now("rst_async", '0);
    step();
    check_now("rst_hold", '0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_now("rst_after", '0);
    end

    for (int r = 0; r < 8; r++) begin
      l = int'($urandom_range(0, 7));
      p = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 1));
      if (l == 0)      n = 4;
      else if (a != 0) n = 2 * l * (p + 1) + 2;
      else             n = l * (p + 1) + 3;
      run("rand", l, p, a, n);
      if (a != 0 && l > 0) begin
        do_stop("rand_stop", int'(model(l, p, a, n - 1) >> 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
